// File: rtl/back_propagation_nn.sv
// Online-training 4-3-2 perceptron in signed Q8.8 fixed point.
// A fixed six-state loop runs forward pass, back-propagation and weight update.
module back_propagation_nn #(
    parameter int LR_SHIFT = 6,
    parameter int WW       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic signed [8:0] x0,
    input  logic signed [8:0] x1,
    input  logic signed [8:0] x2,
    input  logic signed [8:0] x3,
    input  logic signed [8:0] desired_y0,
    input  logic signed [8:0] desired_y1,
    output logic              y0,
    output logic              y1
);
    localparam int AW = 48;
    localparam int EW = WW + 8;
    localparam logic signed [AW-1:0] SMAX  = (AW'(1) <<< (WW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] SMIN  = ~SMAX;
    localparam logic signed [WW-1:0] ONE   = WW'(256);
    localparam logic signed [WW-1:0] HALF  = WW'(128);
    localparam logic signed [WW-1:0] W_POS = WW'(64);
    localparam logic signed [WW-1:0] W_NEG = -W_POS;

    typedef enum logic [2:0] {S_LOAD, S_HID, S_OUT, S_DOUT, S_DHID, S_UPD} state_t;

    state_t r_state, w_state_nx;

    logic signed [8:0]    r_x  [4];
    logic signed [WW-1:0] r_t  [2];
    logic signed [WW-1:0] r_w1 [3][4];
    logic signed [WW-1:0] r_b1 [3];
    logic signed [WW-1:0] r_w2 [2][3];
    logic signed [WW-1:0] r_b2 [2];
    logic signed [WW-1:0] r_h  [3];
    logic signed [WW-1:0] r_o  [2];
    logic signed [WW-1:0] r_d  [2];
    logic signed [EW-1:0] r_e  [3];
    logic                 r_y0, r_y1;

    logic signed [WW-1:0] w_h   [3];
    logic signed [WW-1:0] w_o   [2];
    logic signed [WW-1:0] w_d   [2];
    logic signed [EW-1:0] w_e   [3];
    logic signed [WW-1:0] w_w1n [3][4];
    logic signed [WW-1:0] w_b1n [3];
    logic signed [WW-1:0] w_w2n [2][3];
    logic signed [WW-1:0] w_b2n [2];

    function automatic logic signed [WW-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SMAX) return SMAX[WW-1:0];
        if (v < SMIN) return SMIN[WW-1:0];
        return v[WW-1:0];
    endfunction

    // f(s) = clamp(s/4 + 0.5, 0, 1.0)
    function automatic logic signed [WW-1:0] act(input logic signed [WW-1:0] s);
        logic signed [AW-1:0] q;
        q = (AW'(s) >>> 2) + AW'(128);
        if (q < 0) return '0;
        if (q > AW'(256)) return ONE;
        return q[WW-1:0];
    endfunction

    // Derivative of the clamp: full slope inside the linear region, 1/8 at the rails
    function automatic logic signed [AW-1:0] slope(input logic signed [AW-1:0] v,
                                                   input logic signed [WW-1:0] a);
        if (a > 0 && a < ONE) return v;
        return v >>> 3;
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_LOAD;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = S_LOAD;
        unique case (r_state)
            S_LOAD:  w_state_nx = S_HID;
            S_HID:   w_state_nx = S_OUT;
            S_OUT:   w_state_nx = S_DOUT;
            S_DOUT:  w_state_nx = S_DHID;
            S_DHID:  w_state_nx = S_UPD;
            S_UPD:   w_state_nx = S_LOAD;
            default: w_state_nx = S_LOAD;
        endcase
    end

    always_comb begin
        logic signed [AW-1:0] acc;
        acc   = '0;
        w_h   = '{default: '0};
        w_o   = '{default: '0};
        w_d   = '{default: '0};
        w_e   = '{default: '0};
        w_w1n = '{default: '{default: '0}};
        w_b1n = '{default: '0};
        w_w2n = '{default: '{default: '0}};
        w_b2n = '{default: '0};
        for (int j = 0; j < 3; j++) begin
            acc = AW'(r_b1[j]);
            for (int i = 0; i < 4; i++)
                acc = acc + ((AW'(r_w1[j][i]) * AW'(r_x[i])) >>> 8);
            w_h[j] = act(sat(acc));
        end
        for (int k = 0; k < 2; k++) begin
            acc = AW'(r_b2[k]);
            for (int j = 0; j < 3; j++)
                acc = acc + ((AW'(r_w2[k][j]) * AW'(r_h[j])) >>> 8);
            w_o[k] = act(sat(acc));
            w_d[k] = sat(slope(AW'(r_t[k]) - AW'(r_o[k]), r_o[k]));
        end
        // Hidden error reads w2 before this iteration's update
        for (int j = 0; j < 3; j++) begin
            acc = '0;
            for (int k = 0; k < 2; k++)
                acc = acc + AW'(r_w2[k][j]) * AW'(r_d[k]);
            w_e[j] = EW'(slope(acc >>> 8, r_h[j]));
        end
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++)
                w_w2n[k][j] = sat(AW'(r_w2[k][j])
                                  + ((AW'(r_d[k]) * AW'(r_h[j])) >>> (8 + LR_SHIFT)));
            w_b2n[k] = sat(AW'(r_b2[k]) + (AW'(r_d[k]) >>> LR_SHIFT));
        end
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 4; i++)
                w_w1n[j][i] = sat(AW'(r_w1[j][i])
                                  + ((AW'(r_e[j]) * AW'(r_x[i])) >>> (8 + LR_SHIFT)));
            w_b1n[j] = sat(AW'(r_b1[j]) + (AW'(r_e[j]) >>> LR_SHIFT));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int j = 0; j < 3; j++) begin
                for (int i = 0; i < 4; i++)
                    r_w1[j][i] <= (((i + j) % 2) == 0) ? W_POS : W_NEG;
                r_b1[j] <= '0;
                r_h[j]  <= '0;
                r_e[j]  <= '0;
            end
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 3; j++)
                    r_w2[k][j] <= (((j + k) % 2) == 0) ? W_POS : W_NEG;
                r_b2[k] <= '0;
                r_o[k]  <= '0;
                r_d[k]  <= '0;
                r_t[k]  <= '0;
            end
            for (int i = 0; i < 4; i++)
                r_x[i] <= '0;
            r_y0 <= 1'b0;
            r_y1 <= 1'b0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    r_x[0] <= x0;
                    r_x[1] <= x1;
                    r_x[2] <= x2;
                    r_x[3] <= x3;
                    r_t[0] <= (desired_y0 > 0) ? ONE : '0;
                    r_t[1] <= (desired_y1 > 0) ? ONE : '0;
                end
                S_HID:  r_h <= w_h;
                S_OUT: begin
                    r_o  <= w_o;
                    r_y0 <= (w_o[0] >= HALF);
                    r_y1 <= (w_o[1] >= HALF);
                end
                S_DOUT: r_d <= w_d;
                S_DHID: r_e <= w_e;
                S_UPD: begin
                    r_w1 <= w_w1n;
                    r_b1 <= w_b1n;
                    r_w2 <= w_w2n;
                    r_b2 <= w_b2n;
                end
                default: ;
            endcase
        end
    end

    assign y0 = r_y0;
    assign y1 = r_y1;
endmodule

// File: tb/tb_back_propagation_nn.sv
// Directed bench for back_propagation_nn: reset, forward pass, training, input hold, saturation.
module tb_back_propagation_nn;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic signed [8:0] x0, x1, x2, x3, dy0, dy1;
    logic y0, y1;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    back_propagation_nn #(.LR_SHIFT(6), .WW(16)) dut (
        .CLK(CLK), .RST(RST),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .desired_y0(dy0), .desired_y1(dy1),
        .y0(y0), .y1(y1)
    );

    task automatic set_in(input int a, input int b, input int c, input int d,
                          input int t0, input int t1);
        x0 = 9'(a); x1 = 9'(b); x2 = 9'(c); x3 = 9'(d);
        dy0 = 9'(t0); dy1 = 9'(t1);
    endtask

    // Leaves the bench at a falling edge with reset just released
    task automatic apply_reset();
        @(posedge CLK);
        #3 RST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_y got y0=%0b y1=%0b want 0 0", y0, y1);
        end
        n_checks++;
        if (int'(dut.r_state) !== 0) begin
            n_fail++;
            $display("FAIL reset_state got %0d want 0", int'(dut.r_state));
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(posedge CLK);
            #1;
            n_checks++;
            if (int'(dut.r_state) !== (c % 6)) begin
                n_fail++;
                $display("FAIL state_seq edge%0d got %0d want %0d", c, int'(dut.r_state), c % 6);
            end
        end
    endtask

    task automatic test_first_pass();
        set_in(0, 0, 0, 0, 0, 0);
        apply_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b00) begin
            n_fail++;
            $display("FAIL first_pass_edge2 got y0=%0b y1=%0b want 0 0", y0, y1);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b10) begin
            n_fail++;
            $display("FAIL first_pass_edge3 got y0=%0b y1=%0b want 1 0", y0, y1);
        end
        #2 RST = 1'b0;
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset got y0=%0b y1=%0b want 0 0", y0, y1);
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_sample_hold();
        set_in(0, 0, 0, 0, 0, 0);
        apply_reset();
        @(posedge CLK);
        #2 set_in(-256, 255, -256, 255, 0, 1);
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_edge3 got y0=%0b y1=%0b want 1 0", y0, y1);
        end
        repeat (5) @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_edge8 got y0=%0b y1=%0b want 1 0", y0, y1);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b01) begin
            n_fail++;
            $display("FAIL new_sample_edge9 got y0=%0b y1=%0b want 0 1", y0, y1);
        end
        @(posedge CLK);
        #2 set_in(0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_edge14 got y0=%0b y1=%0b want 0 1", y0, y1);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b10) begin
            n_fail++;
            $display("FAIL new_sample_edge15 got y0=%0b y1=%0b want 1 0", y0, y1);
        end
        n_checks++;
        if (int'(dut.r_state) !== 3) begin
            n_fail++;
            $display("FAIL phase_edge15 got %0d want 3", int'(dut.r_state));
        end
    endtask

    task automatic test_convergence();
        set_in(0, 0, 0, 0, 0, 1);
        apply_reset();
        repeat (120) @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b01) begin
            n_fail++;
            $display("FAIL converge_120 got y0=%0b y1=%0b want 0 1", y0, y1);
        end
        for (int n = 1; n <= 4; n++) begin
            repeat (6) @(posedge CLK);
            #1;
            n_checks++;
            if ({y0, y1} !== 2'b01) begin
                n_fail++;
                $display("FAIL converge_stable iter+%0d got y0=%0b y1=%0b want 0 1", n, y0, y1);
            end
        end
    endtask

    task automatic test_saturation();
        set_in(255, 255, 255, 255, 1, 1);
        apply_reset();
        repeat (10000) @(posedge CLK);
        #1;
        for (int n = 0; n < 2; n++) begin
            n_checks++;
            if ({y0, y1} !== 2'b11) begin
                n_fail++;
                $display("FAIL saturate_y pass%0d got y0=%0b y1=%0b want 1 1", n, y0, y1);
            end
            repeat (6) @(posedge CLK);
            #1;
        end
        // Targets are 1.0 so output deltas are never negative: b2 and w2 only grow
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (dut.r_b2[k] < 0) begin
                n_fail++;
                $display("FAIL saturate_b2_%0d got %0d want >= 0", k, dut.r_b2[k]);
            end
        end
        n_checks++;
        if (dut.r_w2[0][0] < 64) begin
            n_fail++;
            $display("FAIL saturate_w2_00 got %0d want >= 64", dut.r_w2[0][0]);
        end
    endtask

    task automatic test_reset_mid();
        set_in(0, 0, 0, 0, 0, 1);
        apply_reset();
        repeat (300) @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_trained got y0=%0b y1=%0b want 0 1", y0, y1);
        end
        repeat (4) @(posedge CLK);
        #1;
        n_checks++;
        if (int'(dut.r_state) !== 4) begin
            n_fail++;
            $display("FAIL mid_in_dhid got %0d want 4", int'(dut.r_state));
        end
        #1 set_in(0, 0, 0, 0, 0, 0);
        RST = 1'b0;
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_y got y0=%0b y1=%0b want 0 0", y0, y1);
        end
        n_checks++;
        if (dut.r_w2[0][0] !== 16'sd64 || dut.r_w2[1][0] !== -16'sd64 || dut.r_b2[0] !== 16'sd0) begin
            n_fail++;
            $display("FAIL mid_reset_w2 got w00=%0d w10=%0d b0=%0d want 64 -64 0",
                     dut.r_w2[0][0], dut.r_w2[1][0], dut.r_b2[0]);
        end
        n_checks++;
        if (dut.r_w1[0][1] !== -16'sd64 || dut.r_w1[1][1] !== 16'sd64 || dut.r_b1[1] !== 16'sd0) begin
            n_fail++;
            $display("FAIL mid_reset_w1 got w01=%0d w11=%0d b1=%0d want -64 64 0",
                     dut.r_w1[0][1], dut.r_w1[1][1], dut.r_b1[1]);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_restart_edge2 got y0=%0b y1=%0b want 0 0", y0, y1);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if ({y0, y1} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_restart_edge3 got y0=%0b y1=%0b want 1 0", y0, y1);
        end
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0);
        test_reset();
        test_first_pass();
        test_sample_hold();
        test_convergence();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
